// File: rtl/ram_access_controller_if.sv
// Request/response bus between the CPU memory request logic and the SRAM controller.
interface ram_access_controller_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddress;
  logic [DATA_WIDTH-1:0] reqData;
  logic                  rspValid;
  logic [DATA_WIDTH-1:0] rspData;

  modport master (
    output reqValid, reqWrite, reqAddress, reqData,
    input  reqReady, rspValid, rspData
  );

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqData,
    output reqReady, rspValid, rspData
  );
endinterface

// File: rtl/ram_access_controller.sv
// Synchronous initiator for an asynchronous SRAM: sequences CE/WE/data around each
// accepted request and returns read data with a one-cycle completion pulse.
module ram_access_controller #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                   clock,
  input  logic                   notReset,
  ram_access_controller_if.slave bus,
  output logic [ADDR_WIDTH-1:0]  memAddress,
  output logic                   memNotChipEnable,
  output logic                   memNotWriteEnable,
  inout  wire  [DATA_WIDTH-1:0]  memIo
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES must be in 1..15");
  end
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
    $error("ACCESS_CYCLES must be in 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            phase_q, phase_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ce_n_q, ce_n_d;
  logic                  we_n_q, we_n_d;
  logic                  drive_q, drive_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Every output is computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    ce_n_d      = ce_n_q;
    we_n_d      = we_n_q;
    drive_d     = drive_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          state_d = SETUP;
          phase_d = SETUP_LOAD;
          write_d = bus.reqWrite;
          wdata_d = bus.reqData;
          addr_d  = bus.reqAddress;
          ce_n_d  = 1'b0;
          we_n_d  = 1'b1;
          drive_d = bus.reqWrite;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (phase_q == 4'd0) begin
          state_d = ACCESS;
          phase_d = ACCESS_LOAD;
          we_n_d  = ~write_q;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      ACCESS: begin
        if (phase_q == 4'd0) begin
          state_d     = HOLD;
          phase_d     = HOLD_LOAD;
          ce_n_d      = 1'b1;
          we_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          // Read data is taken at the end of the access window, while CE is still low.
          if (!write_q) begin
            rsp_data_d = memIo;
          end else begin
            rsp_data_d = rsp_data_q;
          end
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      HOLD: begin
        if (phase_q == 4'd0) begin
          state_d = IDLE;
          phase_d = 4'd0;
          drive_d = 1'b0;
          ready_d = 1'b1;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 4'd0;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        drive_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.reqReady      = ready_q;
  assign bus.rspValid      = rsp_valid_q;
  assign bus.rspData       = rsp_data_q;
  assign memAddress        = addr_q;
  assign memNotChipEnable  = ce_n_q;
  assign memNotWriteEnable = we_n_q;
  assign memIo             = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: SRAM pin models plus a cycle-timeline and memory reference.
module tb_ram_access_controller;
  logic clock = 1'b0;
  logic notReset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ram_access_controller_if #(.ADDR_WIDTH(12), .DATA_WIDTH(4)) bus0 ();
  ram_access_controller_if #(.ADDR_WIDTH(12), .DATA_WIDTH(4)) bus1 ();

  logic [11:0] addr0, addr1;
  logic        ce0, we0, ce1, we1;
  wire  [3:0]  io0, io1;

  ram_access_controller u_dut0 (
    .clock(clock), .notReset(notReset), .bus(bus0),
    .memAddress(addr0), .memNotChipEnable(ce0), .memNotWriteEnable(we0), .memIo(io0)
  );

  ram_access_controller #(.SETUP_CYCLES(3), .ACCESS_CYCLES(4), .HOLD_CYCLES(2)) u_dut1 (
    .clock(clock), .notReset(notReset), .bus(bus1),
    .memAddress(addr1), .memNotChipEnable(ce1), .memNotWriteEnable(we1), .memIo(io1)
  );

  // SRAM models: level-sensitive write, output driven only while a read is selected.
  logic [3:0] ram0 [4096];
  logic [3:0] ram1 [4096];
  logic       tx_write0 = 1'b0;
  always @(posedge clock) if (bus0.reqValid && bus0.reqReady) tx_write0 <= bus0.reqWrite;
  always @(negedge clock) if (!ce0 && !we0) ram0[addr0] <= io0;
  assign io0 = (!ce0 && we0 && !tx_write0) ? ram0[addr0] : 4'bzzzz;
  assign io1 = (!ce1 && we1) ? ram1[addr1] : 4'bzzzz;

  // Reference: expected memory contents and last read value per controller.
  logic [3:0]  model0 [4096];
  logic [3:0]  model1 [4096];
  logic [3:0]  exp_rd [2];
  logic [11:0] written_q [$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic wr, input logic [11:0] a,
                       input logic [3:0] d);
    if (w == 0) begin
      bus0.reqValid = v; bus0.reqWrite = wr; bus0.reqAddress = a; bus0.reqData = d;
    end else begin
      bus1.reqValid = v; bus1.reqWrite = wr; bus1.reqAddress = a; bus1.reqData = d;
    end
  endtask

  task automatic samp(input int w, output logic ce, output logic we, output logic rdy,
                      output logic rv, output logic [3:0] rd, output logic [11:0] ad,
                      output logic [3:0] io);
    if (w == 0) begin
      ce = ce0; we = we0; rdy = bus0.reqReady; rv = bus0.rspValid; rd = bus0.rspData;
      ad = addr0; io = io0;
    end else begin
      ce = ce1; we = we1; rdy = bus1.reqReady; rv = bus1.rspValid; rd = bus1.rspData;
      ad = addr1; io = io1;
    end
  endtask

  function automatic logic [3:0] mem_exp(input int w, input logic [11:0] a);
    return (w == 0) ? model0[a] : model1[a];
  endfunction

  // Called at a falling edge; presents the request, waits for acceptance and checks
  // every cycle up to the first IDLE cycle against the timeline the parameters imply.
  task automatic run_txn(input int w, input logic wr, input logic [11:0] a, input logic [3:0] d,
                         input int S, input int A, input int H, input bit keep, output int acc);
    logic ce, we, rdy, rv;
    logic [3:0] rd, io;
    logic [11:0] ad;
    int n;
    drive(w, 1'b1, wr, a, d);
    samp(w, ce, we, rdy, rv, rd, ad, io);
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clock);
      samp(w, ce, we, rdy, rv, rd, ad, io);
      n++;
    end
    chk("accept_within_bound", 32'(n < 50), 32'd1);
    @(posedge clock);
    @(negedge clock);
    acc = cyc;
    if (!keep) drive(w, 1'b0, wr, a, d);
    if (wr && w == 0) model0[a] = d;
    for (int k = 1; k <= S + A + H + 1; k++) begin
      if (k > 1) @(negedge clock);
      samp(w, ce, we, rdy, rv, rd, ad, io);
      if (!wr && k == S + A + 1) exp_rd[w] = mem_exp(w, a);
      chk("mem_ce_n", 32'(ce), 32'(!(k <= S + A)));
      chk("mem_we_n", 32'(we), 32'(!(wr && k > S && k <= S + A)));
      chk("req_ready", 32'(rdy), 32'(k > S + A + H));
      chk("rsp_valid", 32'(rv), 32'(k == S + A + 1));
      chk("rsp_data", 32'(rd), 32'(exp_rd[w]));
      chk("mem_address", 32'(ad), 32'(a));
      if (wr && k <= S + A + H) chk("mem_io_write", 32'(io), 32'(d));
      if (!wr && k <= S + A) chk("mem_io_read", 32'(io), 32'(mem_exp(w, a)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ce, we, rdy, rv;
    logic [3:0] rd, io;
    logic [11:0] ad, a;
    logic [3:0] d;
    int acc, prev_acc, n;

    for (int i = 0; i < 4096; i++) begin
      ram1[i]   = 4'($urandom);
      model1[i] = ram1[i];
    end
    exp_rd[0] = 4'd0;
    exp_rd[1] = 4'd0;
    drive(0, 1'b0, 1'b0, 12'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 4'd0);
    notReset = 1'b1;
    #2 notReset = 1'b0;
    repeat (2) @(negedge clock);
    for (int w = 0; w < 2; w++) begin
      samp(w, ce, we, rdy, rv, rd, ad, io);
      chk("reset_ce_n", 32'(ce), 32'd1);
      chk("reset_we_n", 32'(we), 32'd1);
      chk("reset_ready", 32'(rdy), 32'd1);
      chk("reset_rsp_valid", 32'(rv), 32'd0);
      chk("reset_rsp_data", 32'(rd), 32'd0);
      chk("reset_address", 32'(ad), 32'd0);
    end
    notReset = 1'b1;
    @(negedge clock);

    // Directed write/read pairs, including both address extremes.
    run_txn(0, 1'b1, 12'h123, 4'hA, 1, 2, 1, 1'b0, acc);
    run_txn(0, 1'b0, 12'h123, 4'h0, 1, 2, 1, 1'b0, acc);
    chk("read_0x123", 32'(bus0.rspData), 32'hA);
    run_txn(0, 1'b1, 12'hFFF, 4'h5, 1, 2, 1, 1'b0, acc);
    run_txn(0, 1'b1, 12'h000, 4'h3, 1, 2, 1, 1'b0, acc);
    run_txn(0, 1'b0, 12'hFFF, 4'h0, 1, 2, 1, 1'b0, acc);
    chk("read_0xfff", 32'(bus0.rspData), 32'h5);
    run_txn(0, 1'b0, 12'h000, 4'h0, 1, 2, 1, 1'b0, acc);
    chk("read_0x000", 32'(bus0.rspData), 32'h3);
    written_q.push_back(12'h123);
    written_q.push_back(12'hFFF);
    written_q.push_back(12'h000);

    // reqValid held high with random alternating writes and reads.
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        a = 12'($urandom);
        d = 4'($urandom);
        written_q.push_back(a);
        run_txn(0, 1'b1, a, d, 1, 2, 1, 1'b1, acc);
      end else begin
        a = written_q[$urandom_range(written_q.size() - 1, 0)];
        run_txn(0, 1'b0, a, 4'h0, 1, 2, 1, 1'b1, acc);
      end
      if (i > 0) chk("accept_spacing", 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
    end
    drive(0, 1'b0, 1'b0, 12'd0, 4'd0);
    @(negedge clock);

    // Reset asserted while the write strobe is low.
    drive(0, 1'b1, 1'b1, 12'h7A5, 4'h9);
    samp(0, ce, we, rdy, rv, rd, ad, io);
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clock);
      samp(0, ce, we, rdy, rv, rd, ad, io);
      n++;
    end
    chk("abort_accept_within_bound", 32'(n < 50), 32'd1);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 12'd0, 4'd0);
    @(negedge clock);
    samp(0, ce, we, rdy, rv, rd, ad, io);
    chk("abort_we_low_before_reset", 32'(we), 32'd0);
    notReset = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      samp(w, ce, we, rdy, rv, rd, ad, io);
      chk("async_reset_ce_n", 32'(ce), 32'd1);
      chk("async_reset_we_n", 32'(we), 32'd1);
      chk("async_reset_ready", 32'(rdy), 32'd1);
      chk("async_reset_rsp_valid", 32'(rv), 32'd0);
      chk("async_reset_rsp_data", 32'(rd), 32'd0);
      chk("async_reset_address", 32'(ad), 32'd0);
    end
    exp_rd[0] = 4'd0;
    exp_rd[1] = 4'd0;
    @(negedge clock);
    notReset = 1'b1;
    @(negedge clock);
    run_txn(0, 1'b0, 12'hFFF, 4'h0, 1, 2, 1, 1'b0, acc);
    run_txn(0, 1'b1, 12'h000, 4'hC, 1, 2, 1, 1'b0, acc);
    run_txn(0, 1'b0, 12'h000, 4'h0, 1, 2, 1, 1'b0, acc);
    chk("post_reset_read", 32'(bus0.rspData), 32'hC);

    // Stretched timing: SETUP=3, ACCESS=4, HOLD=2.
    run_txn(1, 1'b0, 12'h456, 4'h0, 3, 4, 2, 1'b0, acc);
    run_txn(1, 1'b0, 12'hFFF, 4'h0, 3, 4, 2, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
